bisection_ctrl: RTL
===================

Name: bisection_ctrl

Overview:
Sequencer for the user-area root finder. It runs the bisection algorithm over a signed fixed-point interval [a,b]. Each f(x) evaluation is issued to an external function-evaluator datapath through a valid/ready request and a valid response, and the controller tracks the bracket, iteration count, termination and status. It sits between the Wishbone register block (start/config/result) and the evaluator inside the user project.

Parameters:
WIDTH, 32, data width of x, f(x), tol (two's-complement; binary point is the caller's concern)
ITER_W, 8, width of the iteration limit and counter

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
start_i  in  1  one-cycle start pulse; accepted only when busy_o=0
abort_i  in  1  cancel the run; return to IDLE next cycle, no done pulse
a_i  in  WIDTH  lower bound, signed; sampled on an accepted start
b_i  in  WIDTH  upper bound, signed; sampled on an accepted start
tol_i  in  WIDTH  interval-width tolerance, unsigned; sampled on start
max_iter_i  in  ITER_W  midpoint-evaluation limit; sampled on start
eval_valid_o  out  1  evaluation request valid
eval_ready_i  in  1  evaluator accepts the request
eval_x_o  out  WIDTH  x to evaluate
eval_rsp_valid_i  in  1  one-cycle response strobe
eval_fx_i  in  WIDTH  f(x), signed
busy_o  out  1  run in progress
done_o  out  1  one-cycle pulse at termination
root_o  out  WIDTH  result; held until the next accepted start
status_o  out  2  0 CONVERGED, 1 EXACT, 2 MAXITER, 3 BADBRACKET; held
iter_o  out  ITER_W  midpoints evaluated; held

Behaviour:
- Reset: state=IDLE; every output is 0, including root, status, iter and eval_x. Reset has priority over start and abort.
- States: IDLE, REQ_A, WAIT_A, REQ_B, WAIT_B, CHECK, REQ_M, WAIT_M, UPDATE, FINISH.
- IDLE: start_i loads a, b, tol, max_iter and clears iter.
  - If a>=b (signed), go to FINISH with BADBRACKET, root=a, and issue no evaluations.
  - Otherwise go to REQ_A.
- REQ_x: eval_valid_o=1 and eval_x_o holds the operand stable until eval_ready_i=1. The handshake completes in the cycle both are high, then go to WAIT_x.
- WAIT_x: wait for eval_rsp_valid_i; the earliest response is the cycle after acceptance. Any response strobe outside a WAIT state is ignored. There is one outstanding request maximum.
- After f(a):
  - fa==0: EXACT, root=a.
  - Otherwise go to REQ_B.
- After f(b):
  - fb==0: EXACT, root=b.
  - sign(fa)==sign(fb): BADBRACKET, root=a.
  - Otherwise go to CHECK.
- CHECK uses m = a + ((b-a)>>>1) and w = b-a (WIDTH+1-bit internal, unsigned compare against tol).
  - w<=tol: CONVERGED, root=m.
  - Else if iter==max_iter: MAXITER, root=m.
  - Else go to REQ_M with eval_x=m.
  - max_iter=0 therefore yields MAXITER right after the bracket check.
- WAIT_M response: iter increments.
  - fm==0: EXACT, root=m.
  - sign(fm)==sign(fa): a<=m, fa<=fm.
  - Otherwise: b<=m.
  - Then UPDATE, then CHECK.
- FINISH: done_o=1 for one cycle; root, status and iter are registered; next state is IDLE.
- busy_o=1 in every state except IDLE. start_i is ignored while busy.
- abort_i while busy: IDLE next cycle, eval_valid_o drops, root/status/iter keep their previous values, and a late response is ignored. abort_i in IDLE has no effect.
- Reset mid-run behaves like reset from any state. A stale response after reset is ignored.
- Sign test uses the MSB of f; zero is tested explicitly before any sign comparison.

Decomposition:
- Package bisection_pkg: state enum, status codes (ST_CONVERGED/ST_EXACT/ST_MAXITER/ST_BADBRACKET), 2-bit status width constant.
- Sub-module bisection_mid: combinational m and w from a and b, plus the w<=tol compare. It keeps the widened arithmetic out of the FSM.
- The FSM and registers stay in bisection_ctrl.

Test Plan:
- Exact root: model f(x)=x-3, a=0, b=8, tol=0, max=16. Requests are x=0, 8, 4, 2, 3. Expect EXACT, root=3, iter=3, one done pulse.
- Tolerance: f(x)=2x-7, a=0, b=8, tol=1, max=16. Midpoints are 4, 2, 3. Expect CONVERGED, root=3, iter=3.
- Iteration limit: f(x)=2x-7, a=0, b=8, tol=0, max=2. Expect MAXITER, root=3, iter=2. With max=0, expect MAXITER, root=4, iter=0 after exactly 2 evaluations.
- Bad bracket: f(x)=x+10, a=0, b=8 gives BADBRACKET, iter=0 after 2 evaluations. With a=b=5, BADBRACKET occurs with no eval_valid_o ever asserted.
- Handshake: hold eval_ready_i low for 5 cycles and delay each response by 7 cycles. Check eval_x_o stays stable while valid&&!ready, and that the result matches the first scenario. A spurious eval_rsp_valid_i in REQ_M is ignored.
- Control: start during busy is ignored. abort in WAIT_M gives busy=0 next cycle, no done, and the old root/status are kept. wb_rst_i mid-run zeroes all outputs, and a late response is then ignored.

Source files
------------

// File: rtl/bisection_pkg.sv
// Shared types and constants for the bisection root-finder sequencer.
package bisection_pkg;

    localparam int STATUS_W = 2;

    localparam logic [STATUS_W-1:0] ST_CONVERGED  = 2'd0;
    localparam logic [STATUS_W-1:0] ST_EXACT      = 2'd1;
    localparam logic [STATUS_W-1:0] ST_MAXITER    = 2'd2;
    localparam logic [STATUS_W-1:0] ST_BADBRACKET = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ_A,
        S_WAIT_A,
        S_REQ_B,
        S_WAIT_B,
        S_CHECK,
        S_REQ_M,
        S_WAIT_M,
        S_UPDATE,
        S_FINISH
    } state_t;

endpackage

// File: rtl/bisection_mid.sv
// Midpoint and interval-width convergence test for the current bracket [a,b].
module bisection_mid #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_tol,
    output logic [WIDTH-1:0] o_m,
    output logic             o_conv
);

    logic [WIDTH:0] w_w;

    // Width is formed one bit wider so b-a never overflows; with a<b it is
    // non-negative, so an arithmetic halving reduces to dropping bit 0.
    always_comb begin
        w_w    = {i_b[WIDTH-1], i_b} - {i_a[WIDTH-1], i_a};
        o_m    = i_a + w_w[WIDTH:1];
        o_conv = (w_w <= {1'b0, i_tol});
    end

endmodule

// File: rtl/bisection_ctrl.sv
// Bisection sequencer: issues f(x) requests, maintains the bracket and
// reports the root, termination status and midpoint-evaluation count.
module bisection_ctrl
    import bisection_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ITER_W = 8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [WIDTH-1:0]    a_i,
    input  logic [WIDTH-1:0]    b_i,
    input  logic [WIDTH-1:0]    tol_i,
    input  logic [ITER_W-1:0]   max_iter_i,
    output logic                eval_valid_o,
    input  logic                eval_ready_i,
    output logic [WIDTH-1:0]    eval_x_o,
    input  logic                eval_rsp_valid_i,
    input  logic [WIDTH-1:0]    eval_fx_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [WIDTH-1:0]    root_o,
    output logic [STATUS_W-1:0] status_o,
    output logic [ITER_W-1:0]   iter_o
);

    state_t                r_state, w_state_nxt;
    logic [WIDTH-1:0]      r_a, r_b, r_tol, r_x, r_root;
    logic [WIDTH-1:0]      w_a_nxt, w_b_nxt, w_tol_nxt, w_x_nxt;
    logic                  r_fa_neg, w_fa_neg_nxt;
    logic [ITER_W-1:0]     r_max, r_iter, r_iter_q;
    logic [ITER_W-1:0]     w_max_nxt, w_iter_nxt;
    logic [STATUS_W-1:0]   r_status;
    logic                  w_fin;
    logic [WIDTH-1:0]      w_fin_root;
    logic [STATUS_W-1:0]   w_fin_status;
    logic [WIDTH-1:0]      w_m;
    logic                  w_conv;
    logic                  w_fx_zero, w_fx_neg;

    bisection_mid #(.WIDTH(WIDTH)) u_mid (
        .i_a    (r_a),
        .i_b    (r_b),
        .i_tol  (r_tol),
        .o_m    (w_m),
        .o_conv (w_conv)
    );

    assign w_fx_zero    = (eval_fx_i == '0);
    assign w_fx_neg     = eval_fx_i[WIDTH-1];
    assign eval_valid_o = (r_state == S_REQ_A) || (r_state == S_REQ_B) || (r_state == S_REQ_M);
    assign eval_x_o     = r_x;
    assign busy_o       = (r_state != S_IDLE);
    assign done_o       = (r_state == S_FINISH);
    assign root_o       = r_root;
    assign status_o     = r_status;
    assign iter_o       = r_iter_q;

    // Next-state and datapath updates; termination loads the result registers.
    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_tol_nxt    = r_tol;
        w_x_nxt      = r_x;
        w_fa_neg_nxt = r_fa_neg;
        w_max_nxt    = r_max;
        w_iter_nxt   = r_iter;
        w_fin        = 1'b0;
        w_fin_root   = r_root;
        w_fin_status = r_status;

        if (abort_i && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        w_a_nxt    = a_i;
                        w_b_nxt    = b_i;
                        w_tol_nxt  = tol_i;
                        w_max_nxt  = max_iter_i;
                        w_iter_nxt = '0;
                        if ($signed(a_i) >= $signed(b_i)) begin
                            w_fin        = 1'b1;
                            w_fin_root   = a_i;
                            w_fin_status = ST_BADBRACKET;
                        end else begin
                            w_x_nxt     = a_i;
                            w_state_nxt = S_REQ_A;
                        end
                    end
                end
                S_REQ_A: if (eval_ready_i) w_state_nxt = S_WAIT_A;
                S_WAIT_A: begin
                    if (eval_rsp_valid_i) begin
                        if (w_fx_zero) begin
                            w_fin        = 1'b1;
                            w_fin_root   = r_a;
                            w_fin_status = ST_EXACT;
                        end else begin
                            w_fa_neg_nxt = w_fx_neg;
                            w_x_nxt      = r_b;
                            w_state_nxt  = S_REQ_B;
                        end
                    end
                end
                S_REQ_B: if (eval_ready_i) w_state_nxt = S_WAIT_B;
                S_WAIT_B: begin
                    if (eval_rsp_valid_i) begin
                        if (w_fx_zero) begin
                            w_fin        = 1'b1;
                            w_fin_root   = r_b;
                            w_fin_status = ST_EXACT;
                        end else if (w_fx_neg == r_fa_neg) begin
                            w_fin        = 1'b1;
                            w_fin_root   = r_a;
                            w_fin_status = ST_BADBRACKET;
                        end else begin
                            w_state_nxt = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_conv) begin
                        w_fin        = 1'b1;
                        w_fin_root   = w_m;
                        w_fin_status = ST_CONVERGED;
                    end else if (r_iter == r_max) begin
                        w_fin        = 1'b1;
                        w_fin_root   = w_m;
                        w_fin_status = ST_MAXITER;
                    end else begin
                        w_x_nxt     = w_m;
                        w_state_nxt = S_REQ_M;
                    end
                end
                S_REQ_M: if (eval_ready_i) w_state_nxt = S_WAIT_M;
                S_WAIT_M: begin
                    if (eval_rsp_valid_i) begin
                        w_iter_nxt = r_iter + ITER_W'(1);
                        if (w_fx_zero) begin
                            w_fin        = 1'b1;
                            w_fin_root   = r_x;
                            w_fin_status = ST_EXACT;
                        end else begin
                            // fa keeps its sign when a moves to m, so only a is updated.
                            if (w_fx_neg == r_fa_neg) w_a_nxt = r_x;
                            else                      w_b_nxt = r_x;
                            w_state_nxt = S_UPDATE;
                        end
                    end
                end
                S_UPDATE: w_state_nxt = S_CHECK;
                S_FINISH: w_state_nxt = S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
            if (w_fin) w_state_nxt = S_FINISH;
        end
    end

    // State, bracket and result registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_tol    <= '0;
            r_x      <= '0;
            r_fa_neg <= 1'b0;
            r_max    <= '0;
            r_iter   <= '0;
            r_root   <= '0;
            r_status <= '0;
            r_iter_q <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_tol    <= w_tol_nxt;
            r_x      <= w_x_nxt;
            r_fa_neg <= w_fa_neg_nxt;
            r_max    <= w_max_nxt;
            r_iter   <= w_iter_nxt;
            if (w_fin) begin
                r_root   <= w_fin_root;
                r_status <= w_fin_status;
                r_iter_q <= w_iter_nxt;
            end
        end
    end

endmodule
